// File: rtl/matrix_key_scanner.sv
// rtl/matrix_key_scanner.sv - 4x4 active-low key matrix scanner with one shared debounce counter
// A candidate key holds its row while debouncing, so the counter only ever tracks one key.
module matrix_key_scanner #(
  parameter int F_CLK          = 50000000,
  parameter int F_SCAN         = 1000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int P  = F_CLK / F_SCAN;
  localparam int TW = (P > 1) ? $clog2(P) : 1;
  localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(P - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t        state, state_n;
  logic [3:0]    col_m, col_s;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [1:0]    ri, ri_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]    col_p, col_p_n;
  logic [1:0]    col_idx, col_idx_n;
  logic [3:0]    key_code_n;
  logic          key_valid_n, key_down_n;
  logic          one_low;
  logic [1:0]    low_idx;

  assign tick    = (tick_cnt == TICK_LAST);
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  always_comb begin
    row = ~(4'b0001 << ri);
  end

  // Exactly one column low identifies a single candidate key; anything else is ignored.
  always_comb begin
    one_low = 1'b1;
    low_idx = 2'd0;
    case (col_s)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_comb begin
    state_n     = state;
    ri_n        = ri;
    cnt_n       = cnt;
    col_p_n     = col_p;
    col_idx_n   = col_idx;
    key_code_n  = key_code;
    key_valid_n = 1'b0;
    key_down_n  = key_down;
    if (tick) begin
      case (state)
        SCAN: begin
          if (one_low) begin
            col_p_n   = col_s;
            col_idx_n = low_idx;
            cnt_n     = CNT_ONE;
            if (DEBOUNCE_TICKS == 1) begin
              state_n     = PRESSED;
              key_code_n  = {ri, low_idx};
              key_valid_n = 1'b1;
              key_down_n  = 1'b1;
            end else begin
              state_n = DEBOUNCE;
            end
          end else begin
            ri_n = ri + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (col_s == col_p) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_n     = PRESSED;
              key_code_n  = {ri, col_idx};
              key_valid_n = 1'b1;
              key_down_n  = 1'b1;
            end
          end else begin
            state_n = SCAN;
            ri_n    = ri + 2'd1;
          end
        end
        PRESSED: begin
          if (col_s == 4'b1111) begin
            cnt_n = CNT_ONE;
            if (DEBOUNCE_TICKS == 1) begin
              state_n    = SCAN;
              key_down_n = 1'b0;
              ri_n       = ri + 2'd1;
            end else begin
              state_n = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (col_s == 4'b1111) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_n    = SCAN;
              key_down_n = 1'b0;
              ri_n       = ri + 2'd1;
            end
          end else begin
            state_n = PRESSED;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_m     <= 4'b1111;
      col_s     <= 4'b1111;
      tick_cnt  <= '0;
      state     <= SCAN;
      ri        <= 2'd0;
      cnt       <= '0;
      col_p     <= 4'b1111;
      col_idx   <= 2'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      col_m     <= col;
      col_s     <= col_m;
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      state     <= state_n;
      ri        <= ri_n;
      cnt       <= cnt_n;
      col_p     <= col_p_n;
      col_idx   <= col_idx_n;
      key_code  <= key_code_n;
      key_valid <= key_valid_n;
      key_down  <= key_down_n;
    end
  end

endmodule

// File: tb/tb_matrix_key_scanner.sv
// tb/tb_matrix_key_scanner.sv - directed bench for matrix_key_scanner (P=10 clks, 4 debounce ticks)
module tb_matrix_key_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] keys;
  int          tests;
  int          fails;
  int          vcount;

  matrix_key_scanner #(
    .F_CLK(1000),
    .F_SCAN(100),
    .DEBOUNCE_TICKS(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .col(col),
    .row(row),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_down(key_down)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key shorts its column low while its row is driven low.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
  end

  always @(posedge clk) begin
    if (key_valid) vcount++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    keys = 16'h0;
    tests = 0;
    fails = 0;
    vcount = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and free-running row scan (times are clk edges after reset release).
    cyc(1);
    check("rst_row", row, 4'b1110);
    check("rst_valid", key_valid, 1'b0);
    check("rst_down", key_down, 1'b0);
    check("rst_code", key_code, 4'd0);
    cyc(9);  check("scan_r1", row, 4'b1101);
    cyc(10); check("scan_r2", row, 4'b1011);
    cyc(10); check("scan_r3", row, 4'b0111);
    cyc(10); check("scan_wrap", row, 4'b1110);

    // Clean press of row2/col1, held 200 clks.
    keys[9] = 1'b1;
    cyc(30); check("press_row_held", row, 4'b1011);
    cyc(29); check("press_pre_valid", key_valid, 1'b0);
    cyc(1);
    check("press_valid", key_valid, 1'b1);
    check("press_code", key_code, 4'd9);
    check("press_down", key_down, 1'b1);
    check("press_row", row, 4'b1011);
    cyc(1);
    check("press_valid_1clk", key_valid, 1'b0);
    check("press_down_hold", key_down, 1'b1);
    cyc(139);
    keys = 16'h0;
    cyc(39);
    check("rel_down_pre", key_down, 1'b1);
    check("rel_row_pre", row, 4'b1011);
    cyc(1);
    check("rel_down", key_down, 1'b0);
    check("rel_row_next", row, 4'b0111);
    check("rel_count", vcount, 1);

    // Bounce on row0/col3: two matching ticks, then high.
    keys[3] = 1'b1;
    cyc(30); check("bounce_row_held", row, 4'b1110);
    keys = 16'h0;
    cyc(10);
    check("bounce_row_adv", row, 4'b1101);
    check("bounce_down", key_down, 1'b0);

    // Two keys in row1 (col=1001) are ignored.
    keys[5] = 1'b1;
    keys[6] = 1'b1;
    cyc(10); check("multi_row_adv", row, 4'b1011);
    cyc(40);
    check("multi_row_adv2", row, 4'b1011);
    check("multi_count", vcount, 1);

    // Row3/col0 press, release bounce, then clean release.
    keys = 16'h0;
    keys[12] = 1'b1;
    cyc(50);
    check("rb_valid", key_valid, 1'b1);
    check("rb_code", key_code, 4'd12);
    keys[12] = 1'b0;
    cyc(20);
    check("rb_down_mid", key_down, 1'b1);
    keys[12] = 1'b1;
    cyc(20);
    check("rb_down_back", key_down, 1'b1);
    check("rb_count", vcount, 2);
    check("rb_row", row, 4'b0111);
    keys[12] = 1'b0;
    cyc(39); check("rb_down_pre", key_down, 1'b1);
    cyc(1);
    check("rb_down_clear", key_down, 1'b0);
    check("rb_row_next", row, 4'b1110);
    check("rb_code_hold", key_code, 4'd12);
    check("rb_count2", vcount, 2);

    // Reset after two matching debounce ticks on row0/col1.
    keys[1] = 1'b1;
    cyc(20);
    rst_n = 1'b0;
    keys = 16'h0;
    cyc(1);
    rst_n = 1'b1;
    check("mrst_row", row, 4'b1110);
    check("mrst_down", key_down, 1'b0);
    check("mrst_valid", key_valid, 1'b0);
    check("mrst_code", key_code, 4'd0);
    cyc(60);
    check("mrst_count", vcount, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
